// File: rtl/vga_pkg.sv
// Shared VGA timing constants, writer states and pixel type for the VGA sink.
package vga_pkg;

    // 640x480@60 horizontal timing, in VGA pixels
    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_FP    = 10'd16;
    localparam logic [9:0] H_SYNC  = 10'd96;
    localparam logic [9:0] H_BP    = 10'd48;
    localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    // 640x480@60 vertical timing, in lines
    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_FP    = 10'd10;
    localparam logic [9:0] V_SYNC  = 10'd2;
    localparam logic [9:0] V_BP    = 10'd33;
    localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {W_SYNC, W_FILL, W_WAIT} wr_state_t;

    // Stored pixel: 4 bits per channel, {R, G, B}
    typedef logic [11:0] pix_t;

    // Widen each 4-bit channel to 8 bits by nibble replication
    function automatic logic [23:0] pix_expand(input pix_t p);
        return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider plus free-running 800x525 h/v counters with raw sync/visible.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tick,       // last clk of the current VGA pixel
    output logic       pix_first,  // first clk of the current VGA pixel
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       hsync,
    output logic       vsync,
    output logic       visible
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    assign tick      = (div == DIV_LAST);
    assign pix_first = (div == '0);

    // Clock divider: one VGA pixel every CLK_DIV clks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 1'b1;
    end

    // h/v counters; the frame starts at the top of vertical blanking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= '0;
            v <= V_VIS;
        end else if (tick) begin
            if (h == H_TOTAL - 1'b1) begin
                h <= '0;
                v <= (v == V_TOTAL - 1'b1) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign hsync   = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
    assign vsync   = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
    assign visible = (h < H_VIS) && (v < V_VIS);

endmodule

// File: rtl/avst_vga_sink.sv
// Avalon-ST 320x240 pixel sink: ping-pong line buffers, 2x upscale to 640x480@60 VGA.
module avst_vga_sink
    import vga_pkg::*;
#(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] data,
    input  logic        startofpacket,
    input  logic        endofpacket,
    input  logic        valid,
    output logic        ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        frame_err,
    output logic        underflow
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic       tick, pix_first, hs_raw, vs_raw, vis_raw;
    logic [9:0] h, v;

    vga_timing_gen #(.CLK_DIV(CLK_DIV)) u_timing (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .pix_first (pix_first),
        .h         (h),
        .v         (v),
        .hsync     (hs_raw),
        .vsync     (vs_raw),
        .visible   (vis_raw)
    );

    // Only the top nibble of each 10-bit channel is kept
    pix_t beat_pix;
    logic unused_data_bits;
    assign beat_pix         = {data[29:26], data[19:16], data[9:6]};
    assign unused_data_bits = ^{data[25:20], data[15:10], data[5:0]};

    wr_state_t     state, state_nx;
    logic [RW-1:0] row, row_nx;
    logic [CW-1:0] col, col_nx;
    logic [1:0]    full;
    logic [RW-1:0] lb_row [2];
    pix_t          lb [2][IMG_W];
    pix_t          rd_q;
    logic          armed;   // keeps ready low until the first edge after reset

    logic          accept, last_beat, vblank;
    logic          wr_en, wr_done, err, wr_buf;
    logic [CW-1:0] wr_col;

    assign accept    = valid && ready;
    assign vblank    = (v >= V_VIS);
    assign last_beat = (row == ROW_LAST) && (col == COL_LAST);

    // Writer next-state, ready and line-buffer write controls
    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        ready    = 1'b0;
        wr_en    = 1'b0;
        wr_done  = 1'b0;
        err      = 1'b0;
        wr_buf   = row[0];
        wr_col   = col;
        case (state)
            W_SYNC: begin
                ready  = armed && vblank && !full[0];
                wr_buf = 1'b0;
                wr_col = '0;
                if (accept && startofpacket) begin
                    if (endofpacket) begin
                        err = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        row_nx   = '0;
                        col_nx   = CW'(1);
                        state_nx = W_FILL;
                    end
                end
            end
            W_FILL: begin
                ready = 1'b1;
                if (accept) begin
                    if (startofpacket || (endofpacket != last_beat)) begin
                        err      = 1'b1;
                        state_nx = W_SYNC;
                    end else begin
                        wr_en = 1'b1;
                        if (col == COL_LAST) begin
                            wr_done = 1'b1;
                            col_nx  = '0;
                            if (row == ROW_LAST) begin
                                state_nx = W_SYNC;
                            end else begin
                                row_nx = row + 1'b1;
                                if (full[~row[0]]) state_nx = W_WAIT;
                            end
                        end else begin
                            col_nx = col + 1'b1;
                        end
                    end
                end
            end
            W_WAIT: begin
                if (!full[row[0]]) state_nx = W_FILL;
            end
            default: state_nx = W_SYNC;
        endcase
    end

    // Writer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= W_SYNC;
            row   <= '0;
            col   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            col   <= col_nx;
            armed <= 1'b1;
        end
    end

    // Display side: which buffer/row the current display line needs
    logic          disp_buf, row_start, rel_en, buf_ready, row_ok;
    logic [RW-1:0] disp_row;
    logic [CW-1:0] rd_col;

    assign disp_buf  = v[1];
    assign disp_row  = RW'(v >> 1);
    assign rd_col    = vis_raw ? CW'(h >> 1) : '0;
    assign row_start = vis_raw && (h == '0) && pix_first;
    assign rel_en    = vis_raw && v[0] && (h == H_VIS - 1'b1) && tick;
    assign buf_ready = full[disp_buf] && (lb_row[disp_buf] == disp_row);

    // Full flags: set on line completion, cleared on release (release wins) or flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full      <= '0;
            lb_row[0] <= '0;
            lb_row[1] <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
            if (err) begin
                full <= '0;
            end else begin
                if (wr_done) begin
                    full[row[0]]   <= 1'b1;
                    lb_row[row[0]] <= row;
                end
                if (rel_en) full[disp_buf] <= 1'b0;
            end
        end
    end

    // Per-line data check: even lines flag underflow, odd lines may recover
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_ok    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            underflow <= row_start && !v[0] && !buf_ready;
            if (row_start) row_ok <= buf_ready;
        end
    end

    // Line-buffer write port and one-clk read port
    always_ff @(posedge clk) begin
        if (wr_en) lb[wr_buf][wr_col] <= beat_pix;
        rd_q <= lb[disp_buf][rd_col];
    end

    // Two-stage output: sync/blank delayed to line up with the registered colour
    logic [1:0] hs_d, vs_d, vis_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_d                 <= 2'b11;
            vs_d                 <= 2'b11;
            vis_d                <= 2'b00;
            {vga_r, vga_g, vga_b} <= '0;
        end else begin
            hs_d  <= {hs_d[0], hs_raw};
            vs_d  <= {vs_d[0], vs_raw};
            vis_d <= {vis_d[0], vis_raw};
            {vga_r, vga_g, vga_b} <= (vis_d[0] && row_ok) ? pix_expand(rd_q) : 24'd0;
        end
    end

    assign hsync   = hs_d[1];
    assign vsync   = vs_d[1];
    assign blank_n = vis_d[1];

endmodule

// File: tb/tb_avst_vga_sink.sv
// Scoreboard bench for avst_vga_sink: directed frames, pixel checks at fixed display coordinates.
module tb_avst_vga_sink;

    localparam int CLK_DIV = 1;   // shortens vertical blanking so a run fits the cycle budget

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] data = '0;
    logic        startofpacket = 1'b0, endofpacket = 1'b0, valid = 1'b0;
    logic        ready;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, blank_n, frame_err, underflow;

    always #5 clk = ~clk;

    avst_vga_sink #(.IMG_W(320), .IMG_H(240), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .data(data), .startofpacket(startofpacket),
        .endofpacket(endofpacket), .valid(valid), .ready(ready),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .frame_err(frame_err), .underflow(underflow)
    );

    int tests = 0, fails = 0;
    int cyc = 0;                 // clk edges since reset release
    int uf_hi = 0, fe_hi = 0, uf_cyc = -1;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
        logic        bl;
    } px_t;
    px_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input logic [23:0] rgb, input logic bl);
        px_t e;
        e.x = x; e.y = y; e.rgb = rgb; e.bl = bl;
        sb.push_back(e);
    endtask

    function automatic logic [29:0] beat_data(input int r, input int c);
        if (r == 0 && c == 0)   return 30'h3FF00000;
        if (r == 0 && c == 1)   return 30'h000FFC00;
        if (r == 0 && c == 2)   return 30'h000003FF;
        if (r == 1 && c == 0)   return {10'h2C0, 10'h100, 10'h3C0};
        if (r == 2 && c == 319) return 30'h3FFFFFFF;
        if (r == 3 && c == 5)   return {10'h040, 10'h3FF, 10'h080};
        if (r == 4)             return 30'h3FFFFFFF;
        return 30'h0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: pulse bookkeeping and pixel compares against the scoreboard head
    always @(negedge clk) begin : mon
        int  p;
        px_t e;
        if (reset) begin
            if (underflow) begin uf_hi++; uf_cyc = cyc; end
            if (frame_err) fe_hi++;
            if (cyc >= 2 && sb.size() > 0) begin
                p = (480 * 800 + (cyc - 2) / CLK_DIV) % (525 * 800);
                if (sb[0].x == p % 800 && sb[0].y == p / 800) begin
                    e = sb.pop_front();
                    chk($sformatf("pix(%0d,%0d)", e.x, e.y),
                        {7'd0, vga_r, vga_g, vga_b, blank_n}, {7'd0, e.rgb, e.bl});
                end
            end
        end
    end

    // Drive one beat and hold it until accepted; returns at the negedge after acceptance
    task automatic send_beat(input logic [29:0] d, input logic s, input logic e, output bit ok);
        int n;
        ok = 0; n = 0;
        data = d; startofpacket = s; endofpacket = e; valid = 1'b1;
        while (!ready && n < 50000) begin @(negedge clk); n++; end
        if (ready) begin
            @(posedge clk);
            ok = 1;
        end
        @(negedge clk);
        valid = 1'b0; startofpacket = 1'b0; endofpacket = 1'b0;
    endtask

    initial begin
        bit ok, stim_ok;
        int n, lo, hi;
        repeat (3) @(negedge clk);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_ready", ready, 0);
        chk("rst_blank_n", blank_n, 0);
        chk("rst_pulses", {frame_err, underflow}, 0);
        reset = 1'b1;
        #1 chk("ready_before_edge", ready, 0);
        @(negedge clk);
        chk("ready_after_edge", ready, 1);

        push(100, 485, 24'h000000, 1'b0);
        push(0, 0, 24'hFF0000, 1'b1);   push(1, 0, 24'hFF0000, 1'b1);
        push(2, 0, 24'h00FF00, 1'b1);   push(3, 0, 24'h00FF00, 1'b1);
        push(4, 0, 24'h0000FF, 1'b1);   push(5, 0, 24'h0000FF, 1'b1);
        push(6, 0, 24'h000000, 1'b1);   push(640, 0, 24'h000000, 1'b0);
        push(0, 1, 24'hFF0000, 1'b1);   push(1, 1, 24'hFF0000, 1'b1);
        push(2, 1, 24'h00FF00, 1'b1);
        push(0, 2, 24'hBB44FF, 1'b1);   push(2, 2, 24'h000000, 1'b1);
        push(1, 3, 24'hBB44FF, 1'b1);
        push(637, 4, 24'h000000, 1'b1); push(638, 4, 24'hFFFFFF, 1'b1);
        push(639, 4, 24'hFFFFFF, 1'b1); push(639, 5, 24'hFFFFFF, 1'b1);
        push(10, 6, 24'h11FF22, 1'b1);  push(12, 6, 24'h000000, 1'b1);
        push(11, 7, 24'h11FF22, 1'b1);
        push(0, 8, 24'h000000, 1'b1);   push(99, 8, 24'h000000, 1'b1);
        push(0, 9, 24'h000000, 1'b1);   push(98, 9, 24'h000000, 1'b1);
        push(700, 9, 24'h000000, 1'b0);

        fork
            begin : timing
                n = 0;
                while (hsync !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
                lo = 0;
                while (hsync === 1'b0 && lo < 2000) begin @(negedge clk); lo++; end
                hi = 0;
                while (hsync === 1'b1 && hi < 2000) begin @(negedge clk); hi++; end
                chk("hsync_low_clks", lo, 96 * CLK_DIV);
                chk("hsync_period_clks", lo + hi, 800 * CLK_DIV);
                n = 0;
                while (vsync !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
                lo = 0;
                while (vsync === 1'b0 && lo < 5000) begin @(negedge clk); lo++; end
                chk("vsync_low_clks", lo, 1600 * CLK_DIV);
            end
            begin : stim
                stim_ok = 1;
                // Frame with eop on beat 100
                send_beat(30'h3FF00000, 1'b1, 1'b0, ok);
                for (int b = 1; b < 100 && ok; b++) send_beat(30'h0, 1'b0, 1'b0, ok);
                if (ok) send_beat(30'h0, 1'b0, 1'b1, ok);
                if (!ok) chk("err_frame_accept", {31'd0, ok}, 1);
                chk("frame_err_pulse", frame_err, 1);
                @(negedge clk);
                chk("frame_err_width", frame_err, 0);
                // Beats without sop are dropped
                for (int b = 0; b < 10 && ok; b++) send_beat(30'h3FFFFFFF, 1'b0, 1'b0, ok);
                if (!ok) chk("nosop_accept", {31'd0, ok}, 1);
                // Rows 0..3, then 50 beats of row 4 and a stall
                for (int r = 0; r < 5 && stim_ok; r++) begin
                    for (int c = 0; c < ((r == 4) ? 50 : 320) && stim_ok; c++) begin
                        send_beat(beat_data(r, c), (r == 0 && c == 0), 1'b0, ok);
                        if (!ok) begin
                            stim_ok = 0;
                            chk($sformatf("beat_accept r%0d c%0d", r, c), {31'd0, ok}, 1);
                        end
                    end
                end
                while (cyc < 36000 + 9 * 800 + 750) @(negedge clk);
                chk("underflow_clks", uf_hi, 1);
                chk("underflow_at_row8", uf_cyc, 36000 + 8 * 800 + 1);
                chk("frame_err_clks", fe_hi, 1);
                chk("scoreboard_left", sb.size(), 0);
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
